reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer between the dispatcher, the execution write-back bus and the register file. It allocates a rename tag per dispatched instruction and captures execution results out of order. It retires results in program order onto the commit bus, which the register file consumes as `commit_flag`/`rd`/`V`/`Q`. On a mispredicted branch it raises the rollback flag and flushes all entries.

## Interface
Parameters:
- `ROB_SIZE`, 16, number of entries; power of two.
- `ROB_W`, 5, tag width, equal to clog2(ROB_SIZE)+1. Valid tags are 0..ROB_SIZE-1; `ROB_RESET` (= ROB_SIZE) means "no tag".

Ports (clock and reset first):
- `clk_in` in 1: clock, rising edge.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global enable. When low, all state holds.
- `enable_from_dispatcher` in 1: allocate an entry this cycle.
- `rd_from_dispatcher` in 5: destination register; `REG_RESET` (0) means no register write.
- `is_branch_from_dispatcher` in 1: entry is a conditional branch or jalr.
- `pred_taken_from_dispatcher` in 1: predicted direction or target match.
- `rob_id_to_dispatcher` out ROB_W: tag that the next allocation receives (current tail).
- `full_to_dispatcher` out 1: no free entry.
- `Q1_from_dispatcher`, `Q2_from_dispatcher` in ROB_W each: operand tags to look up.
- `ready1_to_dispatcher`, `ready2_to_dispatcher` out 1 each: that tag's value is available.
- `V1_to_dispatcher`, `V2_to_dispatcher` out 32 each: forwarded value.
- `wb_enable_in` in 1: execution result valid.
- `wb_rob_id_in` in ROB_W: tag of the result.
- `wb_value_in` in 32: result value.
- `wb_taken_in` in 1: actual branch outcome.
- `wb_target_in` in 32: correct next PC.
- `commit_flag_to_cdb` out 1: one-cycle retire pulse.
- `rd_to_cdb` out 5: retired destination register.
- `V_to_cdb` out 32: retired value.
- `Q_to_cdb` out ROB_W: retired tag.
- `rollback_flag_to_cdb` out 1: one-cycle flush pulse.
- `rollback_pc_to_cdb` out 32: restart PC.

## Operation
- **Entry fields:** busy, ready, rd, value, is_branch, pred_taken, taken, target.
- **Pointers:** head, tail and a count in 0..ROB_SIZE. Head and tail wrap modulo ROB_SIZE.
- **Allocate:**
  - Condition: `enable_from_dispatcher && !full_to_dispatcher`.
  - Action: write the entry at tail with busy=1 and ready=0, then advance tail.
  - `full_to_dispatcher` is `count == ROB_SIZE`, computed from the registered count. A same-cycle retire does not free space for a same-cycle allocate.
- **Write-back:** `wb_enable_in` sets ready, value, taken and target of entry `wb_rob_id_in`. It is ignored if the entry is not busy or the tag is `ROB_RESET`.
- **Query (combinational):**
  - If the tag equals `ROB_RESET`, ready=0 and V=0.
  - Otherwise, if `wb_enable_in` and the tag matches `wb_rob_id_in`, ready=1 and V=`wb_value_in`.
  - Otherwise ready and V come from the entry (ready && busy).
- **Retire:** when the head entry is busy and ready, in one cycle:
  - Clear the entry, advance head, decrement count.
  - Register the commit outputs: `rd_to_cdb`=rd, `V_to_cdb`=value, `Q_to_cdb`=head tag, `commit_flag_to_cdb`=1.
- **Mispredict:** the retiring head is a branch with taken != pred_taken.
  - The same edge also sets `rollback_flag_to_cdb`=1 and `rollback_pc_to_cdb`=target. The commit pulse for that branch is still emitted.
  - All entries are cleared; head=tail=0, count=0.
  - A same-cycle allocate is discarded.
- **Simultaneous events:**
  - Allocate and retire in one cycle: count unchanged.
  - A write-back to the head entry in the cycle it becomes head retires on the next edge, not the same one.
- **`rdy_in` low:**
  - No allocate, write-back capture or retire.
  - Commit and rollback pulses drive 0.

## Timing
- **Reset values** (asynchronous, while `rst_n_in`=0):
  - All entries not busy; head=tail=count=0.
  - `commit_flag_to_cdb`=0, `rd_to_cdb`=0, `V_to_cdb`=0, `Q_to_cdb`=`ROB_RESET`.
  - `rollback_flag_to_cdb`=0, `rollback_pc_to_cdb`=0.
  - `rob_id_to_dispatcher`=0, `full_to_dispatcher`=0.
- **Latency:**
  - Write-back edge N → earliest commit pulse visible after edge N+1, if the entry is at head.
  - Allocate and commit pulses: at most one each per cycle.
- **Pulse width:** commit and rollback pulses are high for exactly one cycle unless a new retire occurs on the next edge.
- **Dispatcher outputs:** `rob_id_to_dispatcher` and `full_to_dispatcher` are stable for the whole cycle, since they depend only on registered state.
- **Reset mid-operation:** all entries are dropped immediately and no pulse is emitted.

## Structure
- **Shared constants header:** `ROB_SIZE`, `ROB_TYPE`, `ROB_RESET`, `REG_TYPE`, `REG_RESET`, `DATA_TYPE`, `DATA_RESET`. The register file already consumes these.
- **Module structure:** a single module; no sub-module is needed. The two query ports share one forwarding function, replicated inline.

## Test plan
- **Reset:** hold `rst_n_in`=0 mid-stream → all outputs at reset values, `Q_to_cdb`=16, `full_to_dispatcher`=0.
- **In-order retire:**
  - Stimulus: allocate rd=5 (tag 0) and rd=6 (tag 1); write back tag 1=0x22, then tag 0=0x11.
  - Required: commit rd=5/V=0x11/Q=0 one cycle after tag 0's write-back, then rd=6/V=0x22/Q=1 on the following cycle.
- **Full and wrap:**
  - Stimulus: allocate 16 entries, then attempt a 17th.
  - Required: `full_to_dispatcher`=1 and the 17th is ignored. After one retire, the next allocate gets tag 0 and the tail wraps.
- **Forwarding:**
  - Q1=3 with entry 3 ready at 0xAB → ready1=1, V1=0xAB.
  - Q2=4 with same-cycle wb of tag 4 = 0xCD → ready2=1, V2=0xCD.
  - Q1=16 → ready1=0.
- **Mispredict:**
  - Stimulus: branch at head with pred_taken=0, wb_taken=1, target=0x1000; three younger entries outstanding.
  - Required: commit pulse and `rollback_flag_to_cdb`=1 with PC 0x1000 together; next cycle count=0 and `rob_id_to_dispatcher`=0.
- **Stall:**
  - Stimulus: `rdy_in`=0 with a ready head.
  - Required: no commit pulse and state frozen; retire occurs on the first edge with `rdy_in`=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer and its consumers.
// ROB_* describe rename tags, REG_* destination registers and DATA_* result
// values. The register file uses the same definitions.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 5;

  typedef logic [ROB_W-1:0] ROB_TYPE;
  localparam ROB_TYPE ROB_RESET = ROB_TYPE'(ROB_SIZE);  // "no tag"

  typedef logic [4:0] REG_TYPE;
  localparam REG_TYPE REG_RESET = '0;                   // "no register write"

  typedef logic [31:0] DATA_TYPE;
  localparam DATA_TYPE DATA_RESET = '0;

  // One in-flight instruction.
  typedef struct packed {
    logic     busy;
    logic     ready;
    REG_TYPE  rd;
    DATA_TYPE value;
    logic     is_branch;
    logic     pred_taken;
    logic     taken;
    DATA_TYPE target;
  } rob_entry_t;

  // Result of an operand-tag lookup.
  typedef struct packed {
    logic     ready;
    DATA_TYPE value;
  } fwd_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer.
//   - Dispatcher side: allocates the tag at tail (rob_id_to_dispatcher),
//     reports full, and answers two operand-tag lookups with forwarding.
//   - Write-back side: captures out-of-order results by tag.
//   - Commit side: retires the head entry in program order as a registered
//     one-cycle pulse (commit_flag/rd/V/Q) and flushes everything on a
//     mispredicted branch (rollback_flag/rollback_pc).
// rdy_in low freezes all state and suppresses the pulses.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  // dispatcher
  input  logic             enable_from_dispatcher,
  input  REG_TYPE          rd_from_dispatcher,
  input  logic             is_branch_from_dispatcher,
  input  logic             pred_taken_from_dispatcher,
  output logic [ROB_W-1:0] rob_id_to_dispatcher,
  output logic             full_to_dispatcher,
  input  logic [ROB_W-1:0] Q1_from_dispatcher,
  input  logic [ROB_W-1:0] Q2_from_dispatcher,
  output logic             ready1_to_dispatcher,
  output logic             ready2_to_dispatcher,
  output DATA_TYPE         V1_to_dispatcher,
  output DATA_TYPE         V2_to_dispatcher,
  // execution write-back
  input  logic             wb_enable_in,
  input  logic [ROB_W-1:0] wb_rob_id_in,
  input  DATA_TYPE         wb_value_in,
  input  logic             wb_taken_in,
  input  DATA_TYPE         wb_target_in,
  // commit bus
  output logic             commit_flag_to_cdb,
  output REG_TYPE          rd_to_cdb,
  output DATA_TYPE         V_to_cdb,
  output logic [ROB_W-1:0] Q_to_cdb,
  output logic             rollback_flag_to_cdb,
  output DATA_TYPE         rollback_pc_to_cdb
);

  localparam int               IDX_W    = ROB_W - 1;
  localparam logic [ROB_W-1:0] TAG_NONE = ROB_W'(ROB_SIZE);

  rob_entry_t       rob_q [ROB_SIZE];
  rob_entry_t       rob_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_W-1:0] count_q, count_d;

  logic             commit_flag_q, commit_flag_d;
  REG_TYPE          rd_cdb_q, rd_cdb_d;
  DATA_TYPE         v_cdb_q, v_cdb_d;
  logic [ROB_W-1:0] q_cdb_q, q_cdb_d;
  logic             rollback_flag_q, rollback_flag_d;
  DATA_TYPE         rollback_pc_q, rollback_pc_d;

  rob_entry_t       head_e;
  logic             do_alloc, do_retire, do_wb, mispredict;
  logic [IDX_W-1:0] wb_idx;

  assign full_to_dispatcher   = (count_q == ROB_W'(ROB_SIZE));
  assign rob_id_to_dispatcher = {1'b0, tail_q};

  // Operand lookup: a same-cycle write-back wins over the stored entry.
  function automatic fwd_t lookup(input logic [ROB_W-1:0] tag);
    fwd_t r;
    r.ready = 1'b0;
    r.value = DATA_RESET;
    if (tag < TAG_NONE) begin
      if (wb_enable_in && (tag == wb_rob_id_in)) begin
        r.ready = 1'b1;
        r.value = wb_value_in;
      end else begin
        r.ready = rob_q[tag[IDX_W-1:0]].busy && rob_q[tag[IDX_W-1:0]].ready;
        r.value = rob_q[tag[IDX_W-1:0]].value;
      end
    end
    return r;
  endfunction

  fwd_t fwd1, fwd2;
  always_comb begin
    fwd1 = lookup(Q1_from_dispatcher);
    fwd2 = lookup(Q2_from_dispatcher);
  end
  assign ready1_to_dispatcher = fwd1.ready;
  assign V1_to_dispatcher     = fwd1.value;
  assign ready2_to_dispatcher = fwd2.ready;
  assign V2_to_dispatcher     = fwd2.value;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    rob_d           = rob_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_flag_d   = 1'b0;
    rollback_flag_d = 1'b0;
    rd_cdb_d        = rd_cdb_q;
    v_cdb_d         = v_cdb_q;
    q_cdb_d         = q_cdb_q;
    rollback_pc_d   = rollback_pc_q;

    head_e     = rob_q[head_q];
    wb_idx     = wb_rob_id_in[IDX_W-1:0];
    // full comes from the registered count, so a same-cycle retire never
    // makes room for a same-cycle allocate.
    do_alloc   = rdy_in && enable_from_dispatcher && !full_to_dispatcher;
    // Retire looks only at registered ready: a write-back to the head
    // retires one edge later.
    do_retire  = rdy_in && head_e.busy && head_e.ready;
    mispredict = do_retire && head_e.is_branch &&
                 (head_e.taken != head_e.pred_taken);
    do_wb      = rdy_in && wb_enable_in && (wb_rob_id_in < TAG_NONE) &&
                 rob_q[wb_idx].busy;

    if (do_wb) begin
      rob_d[wb_idx].ready  = 1'b1;
      rob_d[wb_idx].value  = wb_value_in;
      rob_d[wb_idx].taken  = wb_taken_in;
      rob_d[wb_idx].target = wb_target_in;
    end

    if (do_alloc) begin
      rob_d[tail_q]            = '0;
      rob_d[tail_q].busy       = 1'b1;
      rob_d[tail_q].rd         = rd_from_dispatcher;
      rob_d[tail_q].is_branch  = is_branch_from_dispatcher;
      rob_d[tail_q].pred_taken = pred_taken_from_dispatcher;
      tail_d                   = tail_q + IDX_W'(1);
    end

    if (do_retire) begin
      rob_d[head_q] = '0;
      head_d        = head_q + IDX_W'(1);
      commit_flag_d = 1'b1;
      rd_cdb_d      = head_e.rd;
      v_cdb_d       = head_e.value;
      q_cdb_d       = {1'b0, head_q};
    end

    unique case ({do_alloc, do_retire})
      2'b10:   count_d = count_q + ROB_W'(1);
      2'b01:   count_d = count_q - ROB_W'(1);
      default: count_d = count_q;
    endcase

    // Flush drops every entry, including one allocated on this same edge.
    if (mispredict) begin
      for (int i = 0; i < ROB_SIZE; i++) rob_d[i] = '0;
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
      rollback_flag_d = 1'b1;
      rollback_pc_d   = head_e.target;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: the entry array is reset too, because its busy bits must drop
      // asynchronously; the whole entry is cleared so no stale data remains.
      for (int i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_flag_q   <= 1'b0;
      rd_cdb_q        <= REG_RESET;
      v_cdb_q         <= DATA_RESET;
      q_cdb_q         <= TAG_NONE;
      rollback_flag_q <= 1'b0;
      rollback_pc_q   <= DATA_RESET;
    end else begin
      rob_q           <= rob_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_flag_q   <= commit_flag_d;
      rd_cdb_q        <= rd_cdb_d;
      v_cdb_q         <= v_cdb_d;
      q_cdb_q         <= q_cdb_d;
      rollback_flag_q <= rollback_flag_d;
      rollback_pc_q   <= rollback_pc_d;
    end
  end

  assign commit_flag_to_cdb   = commit_flag_q;
  assign rd_to_cdb            = rd_cdb_q;
  assign V_to_cdb             = v_cdb_q;
  assign Q_to_cdb             = q_cdb_q;
  assign rollback_flag_to_cdb = rollback_flag_q;
  assign rollback_pc_to_cdb   = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based program-order model
// is compared with the DUT on every falling edge, and directed scenarios
// add hand-computed literal expectations.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        en, is_br, pred;
  logic [4:0]  rd_in;
  logic [4:0]  q1, q2;
  logic        wb_en, wb_taken;
  logic [4:0]  wb_id;
  logic [31:0] wb_val, wb_tgt;

  logic [4:0]  rob_id, q_cdb, rd_cdb;
  logic        full, rdy1, rdy2, commit, rollback;
  logic [31:0] v1, v2, v_cdb, rb_pc;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk_in                    (clk),
    .rst_n_in                  (rst_n),
    .rdy_in                    (rdy),
    .enable_from_dispatcher    (en),
    .rd_from_dispatcher        (rd_in),
    .is_branch_from_dispatcher (is_br),
    .pred_taken_from_dispatcher(pred),
    .rob_id_to_dispatcher      (rob_id),
    .full_to_dispatcher        (full),
    .Q1_from_dispatcher        (q1),
    .Q2_from_dispatcher        (q2),
    .ready1_to_dispatcher      (rdy1),
    .ready2_to_dispatcher      (rdy2),
    .V1_to_dispatcher          (v1),
    .V2_to_dispatcher          (v2),
    .wb_enable_in              (wb_en),
    .wb_rob_id_in              (wb_id),
    .wb_value_in               (wb_val),
    .wb_taken_in               (wb_taken),
    .wb_target_in              (wb_tgt),
    .commit_flag_to_cdb        (commit),
    .rd_to_cdb                 (rd_cdb),
    .V_to_cdb                  (v_cdb),
    .Q_to_cdb                  (q_cdb),
    .rollback_flag_to_cdb      (rollback),
    .rollback_pc_to_cdb        (rb_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- program-order model ----------------
  typedef struct {
    bit        ready;
    bit [4:0]  rd;
    bit [31:0] value;
    bit        is_br, pred, taken;
    bit [31:0] target;
  } m_ent_t;

  m_ent_t    mq[$];     // in-flight instructions, oldest first
  int        m_head;    // tag of mq[0]
  bit        m_commit, m_rb;
  bit [4:0]  m_rd, m_q;
  bit [31:0] m_v, m_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_head = 0; m_commit = 0; m_rb = 0;
      m_rd = 0; m_v = 0; m_q = 5'd16; m_pc = 0;
    end else begin
      bit     ret, alloc, mis;
      m_ent_t e, n;
      int     off;
      m_commit = 0; m_rb = 0; mis = 0; ret = 0; alloc = 0;
      if (rdy) begin
        ret   = (mq.size() > 0) && mq[0].ready;
        alloc = en && (mq.size() < 16);
        if (ret) e = mq[0];
        if (wb_en && wb_id < 16) begin
          off = (int'(wb_id) - m_head + 16) % 16;
          if (off < mq.size()) begin
            mq[off].ready  = 1;
            mq[off].value  = wb_val;
            mq[off].taken  = wb_taken;
            mq[off].target = wb_tgt;
          end
        end
        if (ret) begin
          void'(mq.pop_front());
          m_commit = 1; m_rd = e.rd; m_v = e.value; m_q = 5'(m_head);
          m_head = (m_head + 1) % 16;
          mis = e.is_br && (e.taken != e.pred);
        end
        if (alloc) begin
          n = '{ready: 0, rd: rd_in, value: 0, is_br: is_br, pred: pred,
                taken: 0, target: 0};
          mq.push_back(n);
        end
        if (mis) begin
          m_rb = 1; m_pc = e.target;
          mq.delete(); m_head = 0;
        end
      end
    end
  end

  function automatic void exp_fwd(input logic [4:0] tag, output bit r,
                                  output bit [31:0] v);
    int off;
    r = 0; v = 0;
    if (tag < 16) begin
      if (wb_en && wb_id == tag) begin
        r = 1; v = wb_val;
      end else begin
        off = (int'(tag) - m_head + 16) % 16;
        if (off < mq.size() && mq[off].ready) begin
          r = 1; v = mq[off].value;
        end
      end
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit r; bit [31:0] v;
      check("commit_flag", commit, m_commit);
      check("rd_to_cdb", rd_cdb, m_rd);
      check("V_to_cdb", v_cdb, m_v);
      check("Q_to_cdb", q_cdb, m_q);
      check("rollback_flag", rollback, m_rb);
      check("rollback_pc", rb_pc, m_pc);
      check("full", full, mq.size() == 16);
      check("rob_id", rob_id, (m_head + mq.size()) % 16);
      exp_fwd(q1, r, v);
      check("ready1", rdy1, r);
      if (r || q1 == 5'd16) check("V1", v1, v);
      exp_fwd(q2, r, v);
      check("ready2", rdy2, r);
      if (r || q2 == 5'd16) check("V2", v2, v);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
    en = 0; is_br = 0; pred = 0; wb_en = 0; wb_taken = 0;
  endtask

  task automatic alloc_op(input logic [4:0] rd, input logic br, input logic pt);
    en = 1; rd_in = rd; is_br = br; pred = pt;
    tick();
  endtask

  task automatic wb_op(input logic [4:0] tag, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
    wb_en = 1; wb_id = tag; wb_val = val; wb_taken = tk; wb_tgt = tgt;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " commit"}, commit, 0);
    check({tag, " Q"}, q_cdb, 16);
    check({tag, " rob_id"}, rob_id, 0);
    check({tag, " full"}, full, 0);
    check({tag, " rollback"}, rollback, 0);
  endtask

  initial begin
    rst_n = 1; rdy = 1; en = 0; is_br = 0; pred = 0; rd_in = 0;
    q1 = 5'd16; q2 = 5'd16;
    wb_en = 0; wb_taken = 0; wb_id = 0; wb_val = 0; wb_tgt = 0;
    #2 rst_n = 0;
    chk_en = 1;
    #1 check_reset_outputs("reset");
    check("reset rd", rd_cdb, 0);
    check("reset V", v_cdb, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // in-order retire
    alloc_op(5'd5, 0, 0);
    check("alloc0 rob_id", rob_id, 1);
    alloc_op(5'd6, 0, 0);
    check("alloc1 rob_id", rob_id, 2);
    wb_op(5'd1, 32'h22, 0, 0);
    check("wb1 no commit", commit, 0);
    wb_op(5'd0, 32'h11, 0, 0);
    check("wb0 edge no commit", commit, 0);
    tick();
    check("retire0 flag", commit, 1);
    check("retire0 rd", rd_cdb, 5);
    check("retire0 V", v_cdb, 32'h11);
    check("retire0 Q", q_cdb, 0);
    tick();
    check("retire1 flag", commit, 1);
    check("retire1 rd", rd_cdb, 6);
    check("retire1 V", v_cdb, 32'h22);
    check("retire1 Q", q_cdb, 1);
    tick();
    check("idle no commit", commit, 0);

    // forwarding (tags 2..5)
    for (int i = 0; i < 4; i++) alloc_op(5'(10 + i), 0, 0);
    wb_op(5'd3, 32'hAB, 0, 0);
    q1 = 5'd3; q2 = 5'd4;
    wb_en = 1; wb_id = 5'd4; wb_val = 32'hCD;
    #1;
    check("fwd entry ready1", rdy1, 1);
    check("fwd entry V1", v1, 32'hAB);
    check("fwd bypass ready2", rdy2, 1);
    check("fwd bypass V2", v2, 32'hCD);
    q1 = 5'd16;
    #1 check("fwd none ready1", rdy1, 0);
    tick();
    wb_op(5'd2, 32'h2, 0, 0);
    wb_op(5'd5, 32'h5, 0, 0);
    q1 = 5'd16; q2 = 5'd16;
    repeat (5) tick();

    // stall with a ready head (tag 6)
    alloc_op(5'd7, 0, 0);
    wb_op(5'd6, 32'h77, 0, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      en = 1; rd_in = 5'd8;
      tick();
      check("stall no commit", commit, 0);
      check("stall rob_id frozen", rob_id, 7);
    end
    rdy = 1;
    tick();
    check("stall release commit", commit, 1);
    check("stall release Q", q_cdb, 6);
    check("stall release V", v_cdb, 32'h77);

    // reset mid-operation with a commit pulse in flight
    alloc_op(5'd1, 0, 0);
    alloc_op(5'd2, 0, 0);
    wb_op(5'd7, 32'h70, 0, 0);
    tick();
    rst_n = 0;
    #1 check_reset_outputs("midreset");
    tick(); tick();
    rst_n = 1;
    tick();

    // full and wrap
    for (int i = 0; i < 16; i++) alloc_op(5'(i + 1), 0, 0);
    check("full after 16", full, 1);
    check("full rob_id", rob_id, 0);
    alloc_op(5'd9, 0, 0);
    check("17th ignored full", full, 1);
    check("17th ignored rob_id", rob_id, 0);
    wb_op(5'd0, 32'h100, 0, 0);
    alloc_op(5'd9, 0, 0);     // retire edge: no room yet
    check("wrap retire flag", commit, 1);
    check("wrap retire Q", q_cdb, 0);
    check("wrap not full", full, 0);
    check("wrap rob_id", rob_id, 0);
    alloc_op(5'd10, 0, 0);
    check("wrap alloc rob_id", rob_id, 1);
    check("wrap full again", full, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();

    // mispredict with three younger entries
    alloc_op(5'd1, 1, 0);
    alloc_op(5'd2, 0, 0);
    alloc_op(5'd3, 0, 0);
    alloc_op(5'd4, 0, 0);
    wb_op(5'd2, 32'h2, 0, 0);
    wb_op(5'd0, 32'h4, 1, 32'h1000);
    alloc_op(5'd9, 0, 0);     // retire+flush edge; this allocate is dropped
    check("mis commit", commit, 1);
    check("mis Q", q_cdb, 0);
    check("mis rollback", rollback, 1);
    check("mis pc", rb_pc, 32'h1000);
    check("mis rob_id", rob_id, 0);
    check("mis full", full, 0);
    tick();
    check("mis rollback pulse ends", rollback, 0);
    check("mis commit pulse ends", commit, 0);
    wb_op(5'd1, 32'h11, 0, 0);  // flushed tag: ignored
    q1 = 5'd1;
    tick();
    check("flushed no commit", commit, 0);
    check("flushed ready1", rdy1, 0);
    q1 = 5'd16;

    // correctly predicted branch
    alloc_op(5'd3, 1, 1);
    wb_op(5'd0, 32'h8, 1, 32'h2000);
    tick();
    check("good br commit", commit, 1);
    check("good br no rollback", rollback, 0);
    check("good br pc held", rb_pc, 32'h1000);
    repeat (3) tick();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
